// File: rtl/cpu7_ifu_fcl.sv
// cpu7_ifu_fcl -- instruction fetch control.
// Tracks in-flight icache requests, discards responses orphaned by a branch
// redirect, parks returning instructions in a small hold buffer while the EXU
// stalls fetch, and drives the active-low one-hot pc_bf mux selects.
// Optional feature: define CPU7_IFU_FCL_PERF_EN to add fcl_perf_stall_cnt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | first cycle out of reset; no fetch, pc_bf takes init value
// ST_RUN   | fetching and decoding
// ST_STALL | EXU held fetch last cycle (counted by the perf counter)
//
// The stall request itself gates the outputs in the same cycle, so RUN and
// STALL only differ in what they mean for the perf counter.

module cpu7_ifu_fcl #(
    parameter int MAX_OUTST = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_addr_ok,
    input  logic        inst_valid,
    input  logic        br_cancel,
    input  logic        exu_ifu_stall_req,
    output logic        inst_req,
    output logic        inst_cancel,
    output logic        fcl_fdp_pcbf_sel_init_bf_l,
    output logic        fcl_fdp_pcbf_sel_old_bf_l,
    output logic        fcl_fdp_pcbf_sel_pcinc_bf_l,
    output logic        fcl_fdp_pcbf_sel_brpc_bf_l,
    output logic        fcl_fdp_dec_valid,
    output logic        fcl_fdp_dec_sel_hold,
    output logic        fcl_fdp_hold_push,
    output logic        fcl_fdp_hold_pop
`ifdef CPU7_IFU_FCL_PERF_EN
    ,
    output logic [31:0] fcl_perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [2:0] MAX3 = 3'(MAX_OUTST);

    state_t     state;
    logic [1:0] outst;
    logic [1:0] drop_cnt;
    logic [1:0] hold_cnt;
    logic [1:0] outst_nxt;
    logic [1:0] drop_nxt;
    logic [1:0] hold_nxt;

    logic       in_init;
    logic       active;
    logic       vld;
    logic       dropped;
    logic       deliver;
    logic       accept;
    logic [2:0] load;

    // Fetch/decode handshakes; stall and redirect act in the same cycle.
    always_comb begin
        in_init = reset | (state == ST_INIT);
        active  = ~in_init & ~exu_ifu_stall_req;
        // A response with nothing outstanding (e.g. stale after reset) is ignored.
        vld     = inst_valid & ~in_init & (outst != 2'd0);
        dropped = vld & (drop_cnt != 2'd0);
        deliver = vld & ~dropped & ~br_cancel;

        fcl_fdp_hold_pop     = active & ~br_cancel & (hold_cnt != 2'd0);
        fcl_fdp_hold_push    = deliver & ~(active & (hold_cnt == 2'd0));
        fcl_fdp_dec_valid    = fcl_fdp_hold_pop | (deliver & active & (hold_cnt == 2'd0));
        fcl_fdp_dec_sel_hold = fcl_fdp_hold_pop;

        // Slots already spoken for: in flight plus parked, less the one leaving now.
        load     = {1'b0, outst} + {1'b0, hold_cnt} - {2'b00, fcl_fdp_dec_valid};
        inst_req = active & ~br_cancel & (load < MAX3);
        accept   = inst_req & inst_addr_ok;

        inst_cancel = ~in_init & br_cancel;

        fcl_fdp_pcbf_sel_init_bf_l  = 1'b1;
        fcl_fdp_pcbf_sel_old_bf_l   = 1'b1;
        fcl_fdp_pcbf_sel_pcinc_bf_l = 1'b1;
        fcl_fdp_pcbf_sel_brpc_bf_l  = 1'b1;
        if (in_init) begin
            fcl_fdp_pcbf_sel_init_bf_l = 1'b0;
        end else if (br_cancel) begin
            fcl_fdp_pcbf_sel_brpc_bf_l = 1'b0;
        end else if (accept) begin
            fcl_fdp_pcbf_sel_pcinc_bf_l = 1'b0;
        end else begin
            fcl_fdp_pcbf_sel_old_bf_l = 1'b0;
        end
    end

    // Counter next-state: a redirect turns everything still in flight into drops.
    always_comb begin
        outst_nxt = outst;
        drop_nxt  = drop_cnt;
        hold_nxt  = hold_cnt;
        if (br_cancel & ~in_init) begin
            drop_nxt  = outst - {1'b0, vld};
            outst_nxt = outst - {1'b0, vld};
            hold_nxt  = 2'd0;
        end else begin
            outst_nxt = outst + {1'b0, accept} - {1'b0, vld};
            drop_nxt  = drop_cnt - {1'b0, dropped};
            hold_nxt  = hold_cnt + {1'b0, fcl_fdp_hold_push} - {1'b0, fcl_fdp_hold_pop};
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_INIT;
            outst    <= 2'd0;
            drop_cnt <= 2'd0;
            hold_cnt <= 2'd0;
        end else begin
            case (state)
                ST_INIT:  state <= ST_RUN;
                ST_RUN:   state <= exu_ifu_stall_req ? ST_STALL : ST_RUN;
                ST_STALL: state <= exu_ifu_stall_req ? ST_STALL : ST_RUN;
                default:  state <= ST_INIT;
            endcase
            outst    <= outst_nxt;
            drop_cnt <= drop_nxt;
            hold_cnt <= hold_nxt;
        end
    end

`ifdef CPU7_IFU_FCL_PERF_EN
    // Count cycles spent in STALL; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            fcl_perf_stall_cnt <= 32'd0;
        end else if (state == ST_STALL) begin
            fcl_perf_stall_cnt <= fcl_perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Testbench for cpu7_ifu_fcl: two instances (MAX_OUTST=1 and 2) share the
// stimulus; a queue-based reference model predicts every output each cycle.
// Define CPU7_IFU_FCL_PERF_EN to also check fcl_perf_stall_cnt.

module tb_cpu7_ifu_fcl;

    localparam logic [3:0] SEL_INIT = 4'b0111;
    localparam logic [3:0] SEL_OLD  = 4'b1011;
    localparam logic [3:0] SEL_INC  = 4'b1101;
    localparam logic [3:0] SEL_BR   = 4'b1110;

    logic clock;
    logic reset;
    logic inst_addr_ok;
    logic inst_valid;
    logic br_cancel;
    logic exu_ifu_stall_req;

    // {req, cancel, sel_init_l, sel_old_l, sel_pcinc_l, sel_brpc_l, dec_valid, sel_hold, push, pop}
    wire [9:0] o1;
    wire [9:0] o2;
`ifdef CPU7_IFU_FCL_PERF_EN
    wire [31:0] perf1;
    wire [31:0] perf2;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cpu7_ifu_fcl #(.MAX_OUTST(1)) u1 (
        .clock                       (clock),
        .reset                       (reset),
        .inst_addr_ok                (inst_addr_ok),
        .inst_valid                  (inst_valid),
        .br_cancel                   (br_cancel),
        .exu_ifu_stall_req           (exu_ifu_stall_req),
        .inst_req                    (o1[9]),
        .inst_cancel                 (o1[8]),
        .fcl_fdp_pcbf_sel_init_bf_l  (o1[7]),
        .fcl_fdp_pcbf_sel_old_bf_l   (o1[6]),
        .fcl_fdp_pcbf_sel_pcinc_bf_l (o1[5]),
        .fcl_fdp_pcbf_sel_brpc_bf_l  (o1[4]),
        .fcl_fdp_dec_valid           (o1[3]),
        .fcl_fdp_dec_sel_hold        (o1[2]),
        .fcl_fdp_hold_push           (o1[1]),
        .fcl_fdp_hold_pop            (o1[0])
`ifdef CPU7_IFU_FCL_PERF_EN
        ,
        .fcl_perf_stall_cnt          (perf1)
`endif
    );

    cpu7_ifu_fcl #(.MAX_OUTST(2)) u2 (
        .clock                       (clock),
        .reset                       (reset),
        .inst_addr_ok                (inst_addr_ok),
        .inst_valid                  (inst_valid),
        .br_cancel                   (br_cancel),
        .exu_ifu_stall_req           (exu_ifu_stall_req),
        .inst_req                    (o2[9]),
        .inst_cancel                 (o2[8]),
        .fcl_fdp_pcbf_sel_init_bf_l  (o2[7]),
        .fcl_fdp_pcbf_sel_old_bf_l   (o2[6]),
        .fcl_fdp_pcbf_sel_pcinc_bf_l (o2[5]),
        .fcl_fdp_pcbf_sel_brpc_bf_l  (o2[4]),
        .fcl_fdp_dec_valid           (o2[3]),
        .fcl_fdp_dec_sel_hold        (o2[2]),
        .fcl_fdp_hold_push           (o2[1]),
        .fcl_fdp_hold_pop            (o2[0])
`ifdef CPU7_IFU_FCL_PERF_EN
        ,
        .fcl_perf_stall_cnt          (perf2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: each in-flight request is a queue entry whose bit
    // says whether its response must be thrown away; parked instructions
    // are just a count.
    bit          mq [2][$];
    int          mh [2];
    bit          m_init [2];
    bit          m_stl [2];
    int unsigned m_perf [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step(input int k, input int mx, input bit r, input bit ao,
                              input bit v, input bit bc, input bit st,
                              output logic [9:0] e);
        bit rq, cn, dv, sh, pu, po, vc, dr, run, dlv;
        logic [3:0] sel;
        rq = 0; cn = 0; dv = 0; sh = 0; pu = 0; po = 0;
        sel = SEL_OLD;
        if (r || m_init[k]) begin
            sel = SEL_INIT;
        end else begin
            run = !st;
            vc  = v && (mq[k].size() > 0);
            dr  = vc && mq[k][0];
            if (bc) begin
                cn  = 1;
                sel = SEL_BR;
                if (vc) void'(mq[k].pop_front());
                for (int i = 0; i < mq[k].size(); i++) mq[k][i] = 1'b1;
                mh[k] = 0;
            end else begin
                dlv = vc && !dr;
                po  = run && (mh[k] > 0);
                dv  = po || (dlv && run && mh[k] == 0);
                sh  = po;
                pu  = dlv && !(run && mh[k] == 0);
                rq  = run && (mq[k].size() + mh[k] - (dv ? 1 : 0) < mx);
                if (rq && ao) sel = SEL_INC;
                if (vc) void'(mq[k].pop_front());
                mh[k] = mh[k] + (pu ? 1 : 0) - (po ? 1 : 0);
                if (rq && ao) mq[k].push_back(1'b0);
            end
        end
        e = {rq, cn, sel, dv, sh, pu, po};
        m_perf[k] = r ? 0 : m_perf[k] + (m_stl[k] ? 1 : 0);
        if (r) begin
            m_init[k] = 1;
            m_stl[k]  = 0;
            mq[k].delete();
            mh[k] = 0;
        end else if (m_init[k]) begin
            m_init[k] = 0;
            m_stl[k]  = 0;
        end else begin
            m_stl[k] = st;
        end
    endtask

    // One clock: drive at negedge, check 1 ns later against the model.
    task automatic step(input bit r, input bit ao, input bit v, input bit bc, input bit st);
        logic [9:0] e;
        @(negedge clock);
        reset = r; inst_addr_ok = ao; inst_valid = v; br_cancel = bc; exu_ifu_stall_req = st;
        #1;
`ifdef CPU7_IFU_FCL_PERF_EN
        if (!r) begin
            chk("u1_perf", perf1, 32'(m_perf[0]));
            chk("u2_perf", perf2, 32'(m_perf[1]));
        end
`endif
        model_step(0, 1, r, ao, v, bc, st, e);
        chk("u1_out", 32'(o1), 32'(e));
        model_step(1, 2, r, ao, v, bc, st, e);
        chk("u2_out", 32'(o2), 32'(e));
    endtask

    typedef struct {
        bit         r, ao, v, bc, st;
        logic [9:0] e;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input bit r, input bit ao, input bit v, input bit bc, input bit st,
                                input bit rq, input bit cn, input logic [3:0] sel,
                                input bit dv, input bit sh, input bit pu, input bit po);
        vec_t m;
        m.r = r; m.ao = ao; m.v = v; m.bc = bc; m.st = st;
        m.e = {rq, cn, sel, dv, sh, pu, po};
        return m;
    endfunction

    initial begin
        // Hand-derived MAX_OUTST=1 trace: reset, fetch, redirect, stall, reset again.
        tbl[0]  = mk(1,1,0,0,0, 0,0,SEL_INIT,0,0,0,0);
        tbl[1]  = mk(1,1,0,0,0, 0,0,SEL_INIT,0,0,0,0);
        tbl[2]  = mk(1,1,0,0,0, 0,0,SEL_INIT,0,0,0,0);
        tbl[3]  = mk(0,1,1,0,0, 0,0,SEL_INIT,0,0,0,0);
        tbl[4]  = mk(0,1,0,0,0, 1,0,SEL_INC ,0,0,0,0);
        tbl[5]  = mk(0,1,1,0,0, 1,0,SEL_INC ,1,0,0,0);
        tbl[6]  = mk(0,1,1,0,0, 1,0,SEL_INC ,1,0,0,0);
        tbl[7]  = mk(0,1,0,1,0, 0,1,SEL_BR  ,0,0,0,0);
        tbl[8]  = mk(0,1,1,0,0, 0,0,SEL_OLD ,0,0,0,0);
        tbl[9]  = mk(0,1,0,0,0, 1,0,SEL_INC ,0,0,0,0);
        tbl[10] = mk(0,1,1,0,0, 1,0,SEL_INC ,1,0,0,0);
        tbl[11] = mk(0,1,1,0,1, 0,0,SEL_OLD ,0,0,1,0);
        tbl[12] = mk(0,1,0,0,1, 0,0,SEL_OLD ,0,0,0,0);
        tbl[13] = mk(0,1,0,0,1, 0,0,SEL_OLD ,0,0,0,0);
        tbl[14] = mk(0,1,0,0,0, 1,0,SEL_INC ,1,1,0,1);
        tbl[15] = mk(0,1,1,0,0, 1,0,SEL_INC ,1,0,0,0);
        tbl[16] = mk(1,1,0,0,0, 0,0,SEL_INIT,0,0,0,0);
        tbl[17] = mk(0,1,1,0,0, 0,0,SEL_INIT,0,0,0,0);
        tbl[18] = mk(0,1,0,0,0, 1,0,SEL_INC ,0,0,0,0);
        tbl[19] = mk(0,1,0,0,0, 0,0,SEL_OLD ,0,0,0,0);

        for (int k = 0; k < 2; k++) begin
            m_init[k] = 1; m_stl[k] = 0; m_perf[k] = 0; mh[k] = 0;
        end
        reset = 1; inst_addr_ok = 0; inst_valid = 0; br_cancel = 0; exu_ifu_stall_req = 0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].ao, tbl[i].v, tbl[i].bc, tbl[i].st);
            chk($sformatf("tbl_%0d", i), 32'(o1), 32'(tbl[i].e));
        end

        // MAX_OUTST=2: two in flight, both return during stall, then two pops.
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        step(0,1,0,0,0);
        step(0,0,1,0,1);
        step(0,0,1,0,1);
        chk("u2_full_no_req", 32'(o2[9]), 32'd0);
        step(0,0,0,0,1);
        step(0,0,0,0,0);
        chk("u2_pop1", 32'({o2[3], o2[2], o2[0]}), 32'h7);
        step(0,0,0,0,0);
        chk("u2_pop2", 32'({o2[3], o2[2], o2[0]}), 32'h7);
        step(0,0,0,0,0);
        chk("u2_empty", 32'(o2[0]), 32'd0);

        // Reset with one in flight and one parked; stale response afterwards.
        step(0,1,0,0,0);
        step(0,1,0,0,0);
        step(0,0,1,0,1);
        step(1,0,0,0,0);
        step(0,1,1,0,0);
        step(0,1,1,0,0);
        chk("u2_stale_ignored", 32'(o2[3]), 32'd0);
        step(0,0,0,0,0);

`ifdef CPU7_IFU_FCL_PERF_EN
        begin
            logic [31:0] p0;
            step(0,0,0,0,0);
            step(0,0,0,0,1);
            p0 = perf1;
            repeat (4) step(0,0,0,0,1);
            step(0,0,0,0,0);
            step(0,0,0,0,0);
            chk("perf_five", perf1 - p0, 32'd5);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
